// File: rtl/serializer_fsm.sv
// serializer_fsm: parallel-to-serial converter for the FIR output path.
// Takes one LENGTH-bit word per valid/ready handshake and emits it LSB-first,
// one bit per serial valid/ready transfer, then pulses o_done once.
module serializer_fsm #(
    parameter int LENGTH = 24
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic [LENGTH-1:0] iv_din,
    input  logic              i_din_valid,
    output logic              o_ready,
    output logic              o_dout,
    output logic              o_dout_valid,
    input  logic              i_ready,
    output logic              o_done
);

    localparam int CNT_W = $clog2(LENGTH) + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LENGTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [LENGTH-1:0] shift_reg, shift_reg_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              ready_n;
    logic              dout_n;
    logic              dout_valid_n;
    logic              done_n;

    // Next-state and next-output decode; every register holds unless a rule fires.
    always_comb begin
        state_n      = state;
        shift_reg_n  = shift_reg;
        cnt_n        = cnt;
        ready_n      = o_ready;
        dout_n       = o_dout;
        dout_valid_n = o_dout_valid;
        done_n       = o_done;

        case (state)
            IDLE: begin
                ready_n = 1'b1;
                // o_ready must already be high, so the edge that raises it never accepts.
                if (o_ready && i_din_valid) begin
                    shift_reg_n  = iv_din;
                    dout_n       = iv_din[0];
                    dout_valid_n = 1'b1;
                    ready_n      = 1'b0;
                    cnt_n        = '0;
                    state_n      = SHIFT;
                end
            end
            SHIFT: begin
                ready_n = 1'b0;
                if (i_ready) begin
                    if (cnt < LAST_IDX) begin
                        // Present the next bit; shift_reg[0] always mirrors o_dout.
                        shift_reg_n = shift_reg >> 1;
                        dout_n      = shift_reg[1];
                        cnt_n       = cnt + 1'b1;
                    end else begin
                        dout_valid_n = 1'b0;
                        dout_n       = 1'b0;
                        done_n       = 1'b1;
                        state_n      = DONE;
                    end
                end
            end
            DONE: begin
                done_n  = 1'b0;
                ready_n = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n      = IDLE;
                ready_n      = 1'b0;
                dout_n       = 1'b0;
                dout_valid_n = 1'b0;
                done_n       = 1'b0;
            end
        endcase
    end

    // State and output registers: reset wins over enable, enable low freezes everything.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            shift_reg    <= '0;
            cnt          <= '0;
            o_ready      <= 1'b0;
            o_dout       <= 1'b0;
            o_dout_valid <= 1'b0;
            o_done       <= 1'b0;
        end else if (i_en) begin
            state        <= state_n;
            shift_reg    <= shift_reg_n;
            cnt          <= cnt_n;
            o_ready      <= ready_n;
            o_dout       <= dout_n;
            o_dout_valid <= dout_valid_n;
            o_done       <= done_n;
        end
    end

endmodule

// File: tb/tb_serializer_fsm.sv
// Testbench for serializer_fsm: table of words with stall/enable gaps, plus
// reset, back-to-back and reset-mid-word sequences. A negedge monitor pushes
// expected bits on every accepted word and pops them on every serial transfer.
module tb_serializer_fsm;

    localparam int LENGTH = 24;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic [LENGTH-1:0] din;
    logic              din_valid;
    logic              rdy_out;
    logic              dout;
    logic              dout_valid;
    logic              ready_in;
    logic              done;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    serializer_fsm #(.LENGTH(LENGTH)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_en         (en),
        .iv_din       (din),
        .i_din_valid  (din_valid),
        .o_ready      (rdy_out),
        .o_dout       (dout),
        .o_dout_valid (dout_valid),
        .i_ready      (ready_in),
        .o_done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_err++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard of expected serial bits
    typedef struct packed {
        logic b;
        logic last;
    } sb_t;
    sb_t sb[$];
    logic upd_prev      = 1'b0;
    logic exp_done_prev = 1'b0;

    always @(negedge clk) begin
        logic exp_done_next;
        sb_t  e;
        exp_done_next = 1'b0;
        if (upd_prev) chk("done_pulse", done, exp_done_prev);
        if (!rst_n) begin
            sb.delete();
        end else if (en) begin
            if (dout_valid === 1'b1 && ready_in) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_bit");
                end else begin
                    e = sb.pop_front();
                    chk("serial_bit", dout, e.b);
                    exp_done_next = e.last;
                end
            end
            if (rdy_out === 1'b1 && din_valid) begin
                for (int k = 0; k < LENGTH; k++) begin
                    e.b    = din[k];
                    e.last = (k == LENGTH - 1);
                    sb.push_back(e);
                end
            end
        end
        upd_prev      = !rst_n || en;
        exp_done_prev = exp_done_next;
    end

    typedef struct {
        logic [LENGTH-1:0] word;
        int st_at;
        int st_len;
        int gp_at;
        int gp_len;
        int lat;
    } vec_t;
    vec_t tbl[5];

    task automatic wait_ready();
        int guard = 0;
        while (rdy_out !== 1'b1 && guard < 60) begin
            step();
            guard++;
        end
        if (rdy_out !== 1'b1) fail_now("ready_timeout");
    endtask

    task automatic run_word(input logic [LENGTH-1:0] w, input int st_at, input int st_len,
                            input int gp_at, input int gp_len, input int exp_lat);
        int ntx, st_rem, gp_rem, a_cyc, guard;
        en        = 1'b1;
        ready_in  = 1'b1;
        din_valid = 1'b0;
        wait_ready();
        din       = w;
        din_valid = 1'b1;
        step();
        a_cyc     = cyc;
        din_valid = 1'b0;
        din       = LENGTH'($urandom);
        chk("accept_dvld", dout_valid, 1);
        chk("accept_ready", rdy_out, 0);
        ntx    = 0;
        st_rem = st_len;
        gp_rem = gp_len;
        guard  = 0;
        while (ntx < LENGTH && guard < 200) begin
            ready_in = 1'b1;
            en       = 1'b1;
            if (ntx == st_at && st_rem > 0) begin
                ready_in = 1'b0;
                st_rem--;
            end else if (ntx == gp_at && gp_rem > 0) begin
                en = 1'b0;
                gp_rem--;
            end
            step();
            guard++;
            if (en && ready_in) begin
                ntx++;
            end else begin
                chk("hold_bit", dout, w[ntx]);
                chk("hold_vld", dout_valid, 1);
            end
        end
        en       = 1'b1;
        ready_in = 1'b1;
        chk("latency", cyc - a_cyc, exp_lat);
        chk("done_dvld", dout_valid, 0);
        chk("done_high", done, 1);
        step();
        chk("done_clear", done, 0);
        chk("ready_back", rdy_out, 1);
    endtask

    initial begin
        int a1, a2, guard, sl;

        tbl[0] = '{24'hA5C3F1, 99, 0, 99, 0, 24};
        tbl[1] = '{24'hA5C3F1,  5, 3, 99, 0, 27};
        tbl[2] = '{24'h3C5A96, 99, 0,  8, 4, 28};
        tbl[3] = '{24'h800000,  0, 2, 23, 1, 27};
        tbl[4] = '{24'h7FFFFF, 23, 4,  1, 2, 30};

        rst_n     = 1'b0;
        en        = 1'b1;
        din       = 24'hABCDEF;
        din_valid = 1'b1;
        ready_in  = 1'b1;

        // Reset with handshakes offered on both sides
        repeat (3) step();
        chk("rst_ready", rdy_out, 0);
        chk("rst_dout", dout, 0);
        chk("rst_dvld", dout_valid, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        step();
        chk("rel_ready", rdy_out, 1);
        chk("rel_no_accept", dout_valid, 0);
        din_valid = 1'b0;
        step();
        chk("idle_dvld", dout_valid, 0);

        // Table-driven words with stalls and enable gaps
        for (int i = 0; i < 5; i++)
            run_word(tbl[i].word, tbl[i].st_at, tbl[i].st_len,
                     tbl[i].gp_at, tbl[i].gp_len, tbl[i].lat);

        // Back-to-back with i_din_valid held high
        wait_ready();
        din       = 24'h000001;
        din_valid = 1'b1;
        step();
        a1  = cyc;
        din = 24'hFFFFFE;
        guard = 0;
        while (rdy_out !== 1'b1 && guard < 60) begin
            step();
            guard++;
        end
        step();
        a2 = cyc;
        din_valid = 1'b0;
        chk("b2b_dvld", dout_valid, 1);
        chk("b2b_period", a2 - a1, LENGTH + 2);
        guard = 0;
        while (done !== 1'b1 && guard < 60) begin
            step();
            guard++;
        end
        if (done !== 1'b1) fail_now("b2b_done_timeout");
        step();

        // Reset mid-word discards the word
        wait_ready();
        din       = 24'h5A5A5A;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        repeat (10) step();
        rst_n = 1'b0;
        step();
        chk("midrst_dvld", dout_valid, 0);
        chk("midrst_done", done, 0);
        chk("midrst_ready", rdy_out, 0);
        rst_n = 1'b1;
        step();
        chk("postrst_ready", rdy_out, 1);
        step();
        chk("postrst_done", done, 0);
        run_word(24'h13579B, 99, 0, 99, 0, LENGTH);

        // Random words with random stalls
        for (int i = 0; i < 4; i++) begin
            sl = $urandom_range(0, 3);
            run_word(LENGTH'($urandom), $urandom_range(0, LENGTH - 1), sl, 99, 0, LENGTH + sl);
        end

        repeat (3) step();
        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/serializer_fsm.md
Name: serializer_fsm

Overview:
- Parallel-to-serial converter for the FIR filter datapath. Accepts one LENGTH-bit word per valid/ready handshake from the FIR output side and shifts it out LSB-first, one bit per accepted transfer.
- Serial side uses a valid/ready handshake: a bit transfers on each enabled clock edge where o_dout_valid and i_ready are both high.
- The serial framing is bit-compatible with deserializer_fsm, so the two blocks can be looped back to each other.

Parameters:
- LENGTH, 24, word width in bits (>= 2).

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst_n  in  1  synchronous reset, active low.
- i_en  in  1  clock enable; when low, all registers hold.
- iv_din  in  LENGTH  parallel word to serialize.
- i_din_valid  in  1  iv_din valid.
- o_ready  out  1  block can accept a word (registered).
- o_dout  out  1  serial data bit (registered).
- o_dout_valid  out  1  o_dout valid (registered).
- i_ready  in  1  downstream accepts the current bit.
- o_done  out  1  one-cycle pulse after the last bit of a word transfers (registered).

Behaviour:
- Internal state: state register (IDLE, SHIFT, DONE), shift_reg[LENGTH-1:0], bit counter cnt of width $clog2(LENGTH)+1.
- Reset: i_rst_n=0 at an edge gives state=IDLE, shift_reg=0, cnt=0, o_ready=0, o_dout=0, o_dout_valid=0, o_done=0.
  - Reset has priority over i_en.
  - Reset mid-word discards the word immediately; no o_done is generated.
- i_en=0: every register holds, including outputs. No handshake completes on either side, even if i_din_valid or i_ready is high.
- All rules below apply only on edges with i_rst_n=1 and i_en=1.
- IDLE:
  - o_ready<=1.
  - Accept when o_ready=1 and i_din_valid=1. On accept: shift_reg<=iv_din, o_dout<=iv_din[0], o_dout_valid<=1, o_ready<=0, cnt<=0, state<=SHIFT.
  - Because o_ready must already be high, the first enabled edge after reset never accepts a word.
- SHIFT:
  - o_ready stays 0. i_din_valid and iv_din are ignored.
  - Transfer (i_ready=1) with cnt<LENGTH-1: shift_reg<=shift_reg>>1, o_dout<=shift_reg[1], cnt<=cnt+1.
  - Transfer (i_ready=1) with cnt==LENGTH-1: o_dout_valid<=0, o_dout<=0, o_done<=1, state<=DONE.
  - i_ready=0: hold o_dout, o_dout_valid, shift_reg and cnt. Stalls of any length are allowed.
- DONE: o_done<=0, o_ready<=1, state<=IDLE.
- Illegal or unencoded state: go to IDLE with all outputs cleared.
- Bit order: bit k of the word is presented during the (k+1)th transfer, k=0..LENGTH-1.
- Timing without stalls:
  - Word accepted at edge A.
  - o_dout_valid is high from after A until after edge A+LENGTH.
  - o_done is high for the single cycle between edges A+LENGTH and A+LENGTH+1.
  - o_ready rises after edge A+LENGTH+1.
  - Earliest next accept is edge A+LENGTH+2, giving a minimum period of LENGTH+2 cycles per word.
- Stall cycles on i_ready add one cycle each to every timing point after the stall.
- i_din_valid held high continuously: one word is accepted each time o_ready is high. Words offered while o_ready=0 are not captured; the upstream holds data until the handshake.

Test Plan:
- Reset: hold i_rst_n=0 for 3 edges with i_din_valid=1 and i_ready=1 -> all outputs 0. o_ready goes to 1 one enabled edge after release. No word is accepted on that edge.
- Single word: iv_din=24'hA5C3F1, i_ready=1 constant -> serial bits 1,0,0,0,1,1,1,1,1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1. o_done pulses one cycle after the 24th bit. o_ready returns high one cycle later.
- Stall: i_ready=0 for 3 cycles after bit 5 transfers -> o_dout holds bit 6 (value 1) with o_dout_valid=1 for 3 extra cycles. Completion is delayed exactly 3 cycles. Word is intact.
- Enable: i_en=0 for 4 cycles mid-word with i_ready=1 -> outputs and cnt frozen, no bits lost or duplicated. Total word time is LENGTH+4 cycles.
- Back-to-back: words 24'h000001 and 24'hFFFFFE offered with i_din_valid held high -> accepts are exactly LENGTH+2 edges apart. Streams are 1 then 23 zeros, followed by 0 then 23 ones.
- Reset mid-word: i_rst_n=0 after 10 bits -> o_dout_valid=0 next edge and no o_done. A following word serializes correctly.
- Loopback into deserializer_fsm (LENGTH=24): random words -> ov_dout equals iv_din for each word.
